// File: rtl/multi_lane_serializer.sv
// multi_lane_serializer
// Captures one whole frame of numInputs words. It then streams the frame as beats of
// numLanes words, using valid/ready flow control. The final beat may be partial: unused
// lanes are zero and their outLaneMask bits are clear. A new frame can be accepted on the
// last-beat handshake, so back-to-back frames stream with no idle cycle between them.
module multi_lane_serializer #(
    parameter int numInputs = 784,
    parameter int dataWidth = 16,
    parameter int numLanes  = 1,
    localparam int numBeats     = (numInputs + numLanes - 1) / numLanes,
    localparam int counterWidth = (numBeats > 1) ? $clog2(numBeats) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [numInputs*dataWidth-1:0]  frameIn,
    input  logic                            frameValid,
    output logic                            frameReady,
    input  logic                            abort,
    output logic [numLanes*dataWidth-1:0]   outData,
    output logic                            outValid,
    input  logic                            outReady,
    output logic [counterWidth-1:0]         outIndex,
    output logic                            outLast,
    output logic [numLanes-1:0]             outLaneMask,
    output logic                            busy
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [counterWidth-1:0] lastBeat = counterWidth'(numBeats - 1);

    state_t                           state;
    logic [numInputs*dataWidth-1:0]   frame_reg;
    logic                             handshake;
    logic                             last_handshake;
    logic                             accept;
    logic [counterWidth-1:0]          next_index;

    // Selects the lanes of one beat out of a whole frame. Lanes past the frame end are zero.
    function automatic logic [numLanes*dataWidth-1:0] beat_data(
        input logic [numInputs*dataWidth-1:0] frame,
        input logic [counterWidth-1:0]        beat
    );
        logic [numLanes*dataWidth-1:0] d;
        d = '0;
        for (int l = 0; l < numLanes; l++) begin
            int e;
            e = int'(beat) * numLanes + l;
            if (e < numInputs) d[l*dataWidth +: dataWidth] = frame[e*dataWidth +: dataWidth];
        end
        return d;
    endfunction

    // Marks which lanes of a beat carry real elements. Only the final beat can be partial.
    function automatic logic [numLanes-1:0] beat_mask(input logic [counterWidth-1:0] beat);
        logic [numLanes-1:0] m;
        m = '0;
        for (int l = 0; l < numLanes; l++) begin
            if (int'(beat) * numLanes + l < numInputs) m[l] = 1'b1;
        end
        return m;
    endfunction

    assign handshake      = outValid & outReady;
    assign last_handshake = handshake & outLast;
    assign frameReady     = !abort & ((state == IDLE) | last_handshake);
    assign accept         = frameValid & frameReady;
    assign next_index     = outIndex + counterWidth'(1);
    assign outValid       = (state == STREAM);
    assign busy           = (state == STREAM);

    // FSM with registered beat outputs. Abort wins over accept and advance. Beat 0 is loaded
    // straight from frameIn, so it appears on the edge that accepts the frame.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    // NOTE: the frame register is reset too, so no stale frame contents survive a reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            frame_reg   <= '0;
            outData     <= '0;
            outIndex    <= '0;
            outLast     <= 1'b0;
            outLaneMask <= '0;
        end else if (abort) begin
            state       <= IDLE;
            outData     <= '0;
            outIndex    <= '0;
            outLast     <= 1'b0;
            outLaneMask <= '0;
        end else if (accept) begin
            state       <= STREAM;
            frame_reg   <= frameIn;
            outData     <= beat_data(frameIn, '0);
            outIndex    <= '0;
            outLast     <= (lastBeat == '0);
            outLaneMask <= beat_mask('0);
        end else if (handshake) begin
            if (outLast) begin
                state       <= IDLE;
                outData     <= '0;
                outIndex    <= '0;
                outLast     <= 1'b0;
                outLaneMask <= '0;
            end else begin
                outData     <= beat_data(frame_reg, next_index);
                outIndex    <= next_index;
                outLast     <= (next_index == lastBeat);
                outLaneMask <= beat_mask(next_index);
            end
        end
    end

endmodule

// File: tb/tb_multi_lane_serializer.sv
// Directed bench for multi_lane_serializer. It uses three instances:
//   a: 784 words x 1 lane, b: 10 words x 4 lanes, c: 3 words x 4 lanes (single beat).
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_multi_lane_serializer;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // instance a
    logic [784*DW-1:0] a_frame;
    logic a_fv, a_fr, a_abort, a_ov, a_or, a_last, a_busy;
    logic [DW-1:0] a_data;
    logic [9:0] a_idx;
    logic [0:0] a_mask;
    // instance b
    logic [10*DW-1:0] b_frame;
    logic b_fv, b_fr, b_abort, b_ov, b_or, b_last, b_busy;
    logic [4*DW-1:0] b_data;
    logic [1:0] b_idx;
    logic [3:0] b_mask;
    // instance c
    logic [3*DW-1:0] c_frame;
    logic c_fv, c_fr, c_abort, c_ov, c_or, c_last, c_busy;
    logic [4*DW-1:0] c_data;
    logic [0:0] c_idx;
    logic [3:0] c_mask;

    multi_lane_serializer #(.numInputs(784), .dataWidth(DW), .numLanes(1)) dut_a (
        .clk(clk), .reset(reset), .frameIn(a_frame), .frameValid(a_fv), .frameReady(a_fr),
        .abort(a_abort), .outData(a_data), .outValid(a_ov), .outReady(a_or), .outIndex(a_idx),
        .outLast(a_last), .outLaneMask(a_mask), .busy(a_busy));

    multi_lane_serializer #(.numInputs(10), .dataWidth(DW), .numLanes(4)) dut_b (
        .clk(clk), .reset(reset), .frameIn(b_frame), .frameValid(b_fv), .frameReady(b_fr),
        .abort(b_abort), .outData(b_data), .outValid(b_ov), .outReady(b_or), .outIndex(b_idx),
        .outLast(b_last), .outLaneMask(b_mask), .busy(b_busy));

    multi_lane_serializer #(.numInputs(3), .dataWidth(DW), .numLanes(4)) dut_c (
        .clk(clk), .reset(reset), .frameIn(c_frame), .frameValid(c_fv), .frameReady(c_fr),
        .abort(c_abort), .outData(c_data), .outValid(c_ov), .outReady(c_or), .outIndex(c_idx),
        .outLast(c_last), .outLaneMask(c_mask), .busy(c_busy));

    task automatic fill_a(input int base);
        for (int i = 0; i < 784; i++) a_frame[i*DW +: DW] = 16'(i + base);
    endtask

    task automatic fill_b(input int base);
        for (int i = 0; i < 10; i++) b_frame[i*DW +: DW] = 16'(base + i);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        a_frame = '0; a_fv = 0; a_abort = 0; a_or = 0;
        b_frame = '0; b_fv = 0; b_abort = 0; b_or = 0;
        c_frame = '0; c_fv = 0; c_abort = 0; c_or = 0;
        repeat (2) @(negedge clk);
        total++;
        if ({a_ov, a_data, a_idx, a_last, a_mask, a_busy} !== '0) begin
            bad++; $display("FAIL reset_a outputs: got %h want 0", {a_ov, a_data, a_idx, a_last, a_mask, a_busy});
        end
        total++;
        if ({b_ov, b_data, b_idx, b_last, b_mask, b_busy} !== '0) begin
            bad++; $display("FAIL reset_b outputs: got %h want 0", {b_ov, b_data, b_idx, b_last, b_mask, b_busy});
        end
        reset = 1'b1;
        #1;
        total++;
        if (a_fr !== 1'b1) begin bad++; $display("FAIL reset_frame_ready: got %b want 1", a_fr); end
    endtask

    // 784 single-lane beats with outReady held high; frameIn is trashed after the accept.
    task automatic test_stream;
        int errs;
        errs = 0;
        @(negedge clk);
        fill_a(0); a_or = 1; a_fv = 1;
        #1;
        total++;
        if (a_fr !== 1'b1 || a_ov !== 1'b0) begin
            bad++; $display("FAIL stream_pre_accept: ready=%b valid=%b want 1/0", a_fr, a_ov);
        end
        @(negedge clk);
        a_fv = 0; a_frame = '1;
        for (int idx = 0; idx < 784; idx++) begin
            if (idx > 0) @(negedge clk);
            if (a_ov !== 1'b1 || a_data !== 16'(idx) || a_idx !== 10'(idx) ||
                a_last !== (idx == 783) || a_mask !== 1'b1 || a_busy !== 1'b1) begin
                if (errs == 0) $display("  stream beat %0d: data=%h idx=%0d last=%b", idx, a_data, a_idx, a_last);
                errs++;
            end
        end
        total++;
        if (errs !== 0) begin bad++; $display("FAIL stream_beats: bad beats=%0d want 0", errs); end
        @(negedge clk);
        total++;
        if (a_ov !== 1'b0 || a_idx !== '0 || a_data !== '0 || a_last !== 1'b0) begin
            bad++; $display("FAIL stream_idle_after: valid=%b idx=%0d data=%h want 0", a_ov, a_idx, a_data);
        end
    endtask

    // Random outReady: outputs must track only accepted handshakes.
    task automatic test_random_ready;
        int exp_idx, hs, cycles, errs;
        exp_idx = 0; hs = 0; cycles = 0; errs = 0;
        fill_a(0); a_or = 1; a_fv = 1;
        @(negedge clk);
        a_fv = 0;
        while (hs < 784 && cycles < 5000) begin
            if (a_ov !== 1'b1 || a_data !== 16'(exp_idx) || a_idx !== 10'(exp_idx) ||
                a_last !== (exp_idx == 783)) begin
                if (errs == 0) $display("  random beat %0d: data=%h idx=%0d", exp_idx, a_data, a_idx);
                errs++;
            end
            a_or = 1'($urandom_range(0, 1));
            if (a_or) begin hs++; exp_idx++; end
            cycles++;
            @(negedge clk);
        end
        a_or = 1;
        total++;
        if (errs !== 0) begin bad++; $display("FAIL random_beats: bad=%0d want 0", errs); end
        total++;
        if (hs !== 784) begin bad++; $display("FAIL random_handshakes: got %0d want 784", hs); end
        total++;
        if (a_ov !== 1'b0) begin bad++; $display("FAIL random_idle_after: valid=%b want 0", a_ov); end
    endtask

    // 10 words over 4 lanes: 3 beats, and the last beat is partial.
    task automatic test_lanes;
        fill_b(16'h0101); b_or = 1; b_fv = 1;
        @(negedge clk);
        b_fv = 0;
        total++;
        if (b_data !== 64'h0104_0103_0102_0101 || b_mask !== 4'b1111 || b_idx !== 2'd0 || b_last !== 1'b0 || b_ov !== 1'b1) begin
            bad++; $display("FAIL lanes_beat0: data=%h mask=%b idx=%0d last=%b", b_data, b_mask, b_idx, b_last);
        end
        @(negedge clk);
        total++;
        if (b_data !== 64'h0108_0107_0106_0105 || b_mask !== 4'b1111 || b_idx !== 2'd1 || b_last !== 1'b0) begin
            bad++; $display("FAIL lanes_beat1: data=%h mask=%b idx=%0d last=%b", b_data, b_mask, b_idx, b_last);
        end
        @(negedge clk);
        total++;
        if (b_data !== 64'h0000_0000_010A_0109 || b_mask !== 4'b0011 || b_idx !== 2'd2 || b_last !== 1'b1) begin
            bad++; $display("FAIL lanes_beat2: data=%h mask=%b idx=%0d last=%b", b_data, b_mask, b_idx, b_last);
        end
        @(negedge clk);
        total++;
        if (b_ov !== 1'b0 || b_mask !== 4'b0000) begin bad++; $display("FAIL lanes_idle: valid=%b mask=%b want 0", b_ov, b_mask); end
    endtask

    // frameValid is held high across two frames. B is taken on A's last handshake, with no gap.
    task automatic test_back_to_back;
        fill_b(16'h0101); b_or = 1; b_fv = 1;
        @(negedge clk);
        fill_b(16'h0201);
        #1;
        total++;
        if (b_fr !== 1'b0 || b_data !== 64'h0104_0103_0102_0101) begin
            bad++; $display("FAIL b2b_a_beat0: ready=%b data=%h", b_fr, b_data);
        end
        @(negedge clk);
        total++;
        if (b_data !== 64'h0108_0107_0106_0105) begin bad++; $display("FAIL b2b_a_beat1: data=%h", b_data); end
        @(negedge clk);
        #1;
        total++;
        if (b_data !== 64'h0000_0000_010A_0109 || b_last !== 1'b1 || b_fr !== 1'b1) begin
            bad++; $display("FAIL b2b_a_last: data=%h last=%b ready=%b", b_data, b_last, b_fr);
        end
        @(negedge clk);
        b_fv = 0;
        total++;
        if (b_ov !== 1'b1 || b_idx !== 2'd0 || b_data !== 64'h0204_0203_0202_0201) begin
            bad++; $display("FAIL b2b_b_beat0: valid=%b idx=%0d data=%h", b_ov, b_idx, b_data);
        end
        @(negedge clk);
        total++;
        if (b_data !== 64'h0208_0207_0206_0205) begin bad++; $display("FAIL b2b_b_beat1: data=%h", b_data); end
        @(negedge clk);
        total++;
        if (b_data !== 64'h0000_0000_020A_0209 || b_last !== 1'b1) begin
            bad++; $display("FAIL b2b_b_beat2: data=%h last=%b", b_data, b_last);
        end
        @(negedge clk);
        total++;
        if (b_ov !== 1'b0) begin bad++; $display("FAIL b2b_idle: valid=%b want 0", b_ov); end
    endtask

    task automatic test_abort;
        fill_a(0); a_or = 1; a_fv = 1;
        @(negedge clk);
        a_fv = 0;
        repeat (5) @(negedge clk);
        total++;
        if (a_idx !== 10'd5) begin bad++; $display("FAIL abort_at_beat5: idx=%0d want 5", a_idx); end
        a_abort = 1;
        #1;
        total++;
        if (a_fr !== 1'b0) begin bad++; $display("FAIL abort_ready_low: got %b want 0", a_fr); end
        @(negedge clk);
        total++;
        if (a_ov !== 1'b0 || a_idx !== '0 || a_data !== '0 || a_busy !== 1'b0) begin
            bad++; $display("FAIL abort_outputs: valid=%b idx=%0d data=%h busy=%b", a_ov, a_idx, a_data, a_busy);
        end
        a_abort = 0;
        #1;
        total++;
        if (a_fr !== 1'b1) begin bad++; $display("FAIL abort_ready_rise: got %b want 1", a_fr); end
        fill_a(16'h0100); a_fv = 1;
        @(negedge clk);
        a_fv = 0;
        total++;
        if (a_ov !== 1'b1 || a_idx !== '0 || a_data !== 16'h0100) begin
            bad++; $display("FAIL abort_restart: valid=%b idx=%0d data=%h", a_ov, a_idx, a_data);
        end
        a_abort = 1; a_fv = 1;
        @(negedge clk);
        total++;
        if (a_ov !== 1'b0) begin bad++; $display("FAIL abort_stream_cancel: valid=%b want 0", a_ov); end
        #1;
        total++;
        if (a_fr !== 1'b0) begin bad++; $display("FAIL abort_idle_ready: got %b want 0", a_fr); end
        @(negedge clk);
        total++;
        if (a_ov !== 1'b0 || a_busy !== 1'b0) begin
            bad++; $display("FAIL abort_idle_no_accept: valid=%b busy=%b want 0", a_ov, a_busy);
        end
        a_abort = 0; a_fv = 0;
    endtask

    task automatic test_reset_mid;
        fill_a(0); a_or = 1; a_fv = 1;
        @(negedge clk);
        a_fv = 0;
        repeat (100) @(negedge clk);
        total++;
        if (a_idx !== 10'd100 || a_data !== 16'd100) begin
            bad++; $display("FAIL reset_mid_beat100: idx=%0d data=%h", a_idx, a_data);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({a_ov, a_data, a_idx, a_last, a_mask, a_busy} !== '0) begin
            bad++; $display("FAIL reset_mid_async: got %h want 0", {a_ov, a_data, a_idx, a_last, a_mask, a_busy});
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (a_fr !== 1'b1 || a_ov !== 1'b0) begin
            bad++; $display("FAIL reset_mid_release: ready=%b valid=%b want 1/0", a_fr, a_ov);
        end
    endtask

    // One beat per frame: outLast is set on beat 0, and the beat holds while outReady is low.
    task automatic test_single_beat;
        @(negedge clk);
        c_frame = {16'h0CCC, 16'h0BBB, 16'h0AAA}; c_or = 0; c_fv = 1;
        @(negedge clk);
        c_fv = 0;
        total++;
        if (c_ov !== 1'b1 || c_data !== 64'h0000_0CCC_0BBB_0AAA || c_mask !== 4'b0111 || c_last !== 1'b1 || c_idx !== 1'b0) begin
            bad++; $display("FAIL single_beat: data=%h mask=%b last=%b", c_data, c_mask, c_last);
        end
        @(negedge clk);
        total++;
        if (c_ov !== 1'b1 || c_data !== 64'h0000_0CCC_0BBB_0AAA || c_last !== 1'b1) begin
            bad++; $display("FAIL single_hold: valid=%b data=%h last=%b", c_ov, c_data, c_last);
        end
        c_or = 1;
        @(negedge clk);
        total++;
        if (c_ov !== 1'b0 || c_data !== '0) begin bad++; $display("FAIL single_done: valid=%b data=%h", c_ov, c_data); end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_random_ready;
        test_lanes;
        test_back_to_back;
        test_abort;
        test_reset_mid;
        test_single_beat;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
